// File: rtl/rsa_modexp.sv
// Iterative RSA modular exponentiation: right-to-left square-and-multiply
// built on a bit-serial (MSB-first) interleaved modular multiplier.
module rsa_modexp #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, REDUCE, SCAN, MUL, SQR, FINISH} state_t;

  state_t               state;
  logic [WIDTH-1:0]     n_reg;
  logic [WIDTH-1:0]     r_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     mul_x;
  logic [WIDTH-1:0]     mul_y;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [AW-1:0]        acc;
  logic [CW-1:0]        step_cnt;

  logic [AW-1:0] n_ext;
  logic [AW-1:0] acc_dbl;
  logic [AW-1:0] acc_red;
  logic [AW-1:0] acc_add;
  logic [AW-1:0] acc_next;
  logic          last_step;

  // One multiplier step: double, reduce, conditionally add x, reduce.
  // The accumulator stays below n, so each reduction needs one subtraction.
  always_comb begin
    n_ext    = {2'b00, n_reg};
    acc_dbl  = acc << 1;
    acc_red  = (acc_dbl >= n_ext) ? acc_dbl - n_ext : acc_dbl;
    acc_add  = mul_y[WIDTH-1] ? acc_red + {2'b00, mul_x} : acc_red;
    acc_next = (acc_add >= n_ext) ? acc_add - n_ext : acc_add;
  end

  assign last_step = (step_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n_reg    <= '0;
      r_reg    <= '0;
      b_reg    <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      e_reg    <= '0;
      acc      <= '0;
      step_cnt <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= modulus;
            error <= 1'b0;
            if (modulus <= WIDTH'(1)) begin
              // Degenerate moduli finish immediately; zero modulus is flagged.
              result <= '0;
              error  <= (modulus == '0);
              done   <= 1'b1;
              state  <= FINISH;
            end else begin
              r_reg    <= WIDTH'(1);
              e_reg    <= exponent;
              mul_x    <= WIDTH'(1);
              mul_y    <= base;
              acc      <= '0;
              step_cnt <= '0;
              busy     <= 1'b1;
              state    <= REDUCE;
            end
          end
        end

        REDUCE, MUL, SQR: begin
          acc      <= acc_next;
          mul_y    <= mul_y << 1;
          step_cnt <= step_cnt + 1'b1;
          if (last_step) begin
            acc      <= '0;
            step_cnt <= '0;
            if (state == REDUCE) begin
              b_reg <= acc_next[WIDTH-1:0];
              state <= SCAN;
            end else if (state == MUL) begin
              r_reg <= acc_next[WIDTH-1:0];
              mul_x <= b_reg;
              mul_y <= b_reg;
              state <= SQR;
            end else begin
              b_reg <= acc_next[WIDTH-1:0];
              e_reg <= e_reg >> 1;
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          if (e_reg == '0) begin
            result <= r_reg;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FINISH;
          end else if (e_reg[0]) begin
            mul_x <= r_reg;
            mul_y <= b_reg;
            state <= MUL;
          end else begin
            mul_x <= b_reg;
            mul_y <= b_reg;
            state <= SQR;
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp: a 16-bit instance for directed and random
// checks, and a 128-bit instance for wide random checks.
module tb_rsa_modexp;

  localparam int W  = 16;
  localparam int WB = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_s;
  logic [W-1:0]  base_s, exp_s, mod_s, res_s;
  logic          busy_s, done_s, err_s;

  logic          start_b;
  logic [WB-1:0] base_b, exp_b, mod_b, res_b;
  logic          busy_b, done_b, err_b;

  rsa_modexp #(.WIDTH(W), .EXP_WIDTH(W)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .base(base_s), .exponent(exp_s),
    .modulus(mod_s), .result(res_s), .busy(busy_s), .done(done_s), .error(err_s));

  rsa_modexp #(.WIDTH(WB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base(base_b), .exponent(exp_b),
    .modulus(mod_b), .result(res_b), .busy(busy_b), .done(done_b), .error(err_b));

  typedef struct {
    logic [127:0] res;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sb_s[$];
  exp_t sb_b[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain square-and-multiply with wide arithmetic.
  function automatic logic [127:0] modexpRef(logic [127:0] b, logic [127:0] e, logic [127:0] m);
    logic [255:0] r, bb, mm;
    if (m == '0) return '0;
    mm = 256'(m);
    r  = 256'(1) % mm;
    bb = 256'(b) % mm;
    for (int i = 0; i < 128; i++) begin
      if (e[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return r[127:0];
  endfunction

  function automatic int expLatency(int w, logic [127:0] e, logic [127:0] m);
    int l, p;
    l = 0;
    p = 0;
    if (m <= 128'(1)) return 1;
    for (int i = 0; i < 128; i++) begin
      if (e[i]) begin
        l = i + 1;
        p++;
      end
    end
    return w + (l + 1) + w * (l + p) + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (done_s === 1'b1) begin
      if (sb_s.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done16: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        x = sb_s.pop_front();
        checkOutput("result16", 128'(res_s), x.res);
        checkOutput("error16", 128'(err_s), 128'(x.err));
        checkOutput("latency16", 128'(cyc), 128'(x.cyc));
        checkOutput("busy_at_done16", 128'(busy_s), 128'(0));
      end
    end
    if (done_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done128: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        x = sb_b.pop_front();
        checkOutput("result128", res_b, x.res);
        checkOutput("error128", 128'(err_b), 128'(x.err));
        checkOutput("latency128", 128'(cyc), 128'(x.cyc));
      end
    end
  end

  always @(posedge clk) begin
    if (cyc > 90000) begin
      $display("[TB] FAIL watchdog: got cycle %0d, expected completion before 90000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  task automatic applyStimulus16(input logic [W-1:0] b, input logic [W-1:0] e,
                                 input logic [W-1:0] m, input bit expect_it);
    @(negedge clk);
    base_s  = b;
    exp_s   = e;
    mod_s   = m;
    start_s = 1'b1;
    if (expect_it)
      sb_s.push_back('{modexpRef(128'(b), 128'(e), 128'(m)), (m == '0), cyc + expLatency(W, 128'(e), 128'(m))});
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic applyStimulus128(input logic [WB-1:0] b, input logic [WB-1:0] e,
                                  input logic [WB-1:0] m);
    @(negedge clk);
    base_b  = b;
    exp_b   = e;
    mod_b   = m;
    start_b = 1'b1;
    sb_b.push_back('{modexpRef(b, e, m), (m == '0), cyc + expLatency(WB, e, m)});
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while ((sb_s.size() != 0 || sb_b.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb_s.size() != 0 || sb_b.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got %0d pending, expected 0 after %0d cycles",
               sb_s.size() + sb_b.size(), limit);
      sb_s.delete();
      sb_b.delete();
    end
  endtask

  initial begin
    logic [W-1:0]  rb, re, rm;
    logic [WB-1:0] wb_b, wb_m;
    int            n;

    reset   = 1'b1;
    start_s = 1'b0;
    base_s  = '0;
    exp_s   = '0;
    mod_s   = '0;
    start_b = 1'b0;
    base_b  = '0;
    exp_b   = '0;
    mod_b   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", 128'(res_s), 128'(0));
    checkOutput("reset_busy", 128'(busy_s), 128'(0));
    checkOutput("reset_done", 128'(done_s), 128'(0));
    checkOutput("reset_error", 128'(err_s), 128'(0));
    reset = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus16(16'd65, 16'd17, 16'd3233, 1'b1);
    checkOutput("busy_in_flight", 128'(busy_s), 128'(1));
    waitIdle(400);
    applyStimulus16(16'd2790, 16'd2753, 16'd3233, 1'b1);
    waitIdle(600);
    applyStimulus16(16'd5000, 16'd1, 16'd3233, 1'b1);
    waitIdle(200);
    applyStimulus16(16'd5000, 16'd0, 16'd3233, 1'b1);
    waitIdle(100);
    applyStimulus16(16'd123, 16'd45, 16'd0, 1'b1);
    waitIdle(20);
    applyStimulus16(16'd123, 16'd45, 16'd1, 1'b1);
    waitIdle(20);

    $display("[TB] start while busy and changing inputs");
    applyStimulus16(16'd65, 16'd17, 16'd3233, 1'b1);
    repeat (5) @(negedge clk);
    base_s  = 16'd1234;
    exp_s   = 16'd3;
    mod_s   = 16'd999;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    waitIdle(400);

    $display("[TB] start during FINISH then right after");
    applyStimulus16(16'd5000, 16'd0, 16'd3233, 1'b1);
    n = 0;
    while (done_s !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 128'(done_s), 128'(1));
    base_s  = 16'd7;
    exp_s   = 16'd3;
    mod_s   = 16'd3233;
    start_s = 1'b1;
    @(negedge clk);
    sb_s.push_back('{modexpRef(128'(7), 128'(3), 128'(3233)), 1'b0, cyc + expLatency(W, 128'(3), 128'(3233))});
    @(negedge clk);
    start_s = 1'b0;
    waitIdle(200);

    $display("[TB] reset mid-run");
    applyStimulus16(16'd2790, 16'd2753, 16'd3233, 1'b0);
    repeat (38) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_result", 128'(res_s), 128'(0));
    checkOutput("abort_busy", 128'(busy_s), 128'(0));
    checkOutput("abort_done", 128'(done_s), 128'(0));
    checkOutput("abort_error", 128'(err_s), 128'(0));
    reset = 1'b0;
    repeat (400) @(negedge clk);
    applyStimulus16(16'd2790, 16'd2753, 16'd3233, 1'b1);
    waitIdle(600);

    $display("[TB] random 16-bit");
    for (int i = 0; i < 25; i++) begin
      rb = 16'($urandom);
      re = 16'($urandom);
      rm = 16'($urandom_range(2, 65535));
      if (i % 8 == 3) rm = 16'(i % 2);
      applyStimulus16(rb, re, rm, 1'b1);
      waitIdle(700);
    end

    $display("[TB] random 128-bit");
    for (int i = 0; i < 12; i++) begin
      wb_b = {$urandom, $urandom, $urandom, $urandom};
      wb_m = {$urandom, $urandom, $urandom, $urandom} | 128'(1);
      applyStimulus128(wb_b, 128'($urandom_range(1, 31)), wb_m);
      waitIdle(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
